hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined RISC-V core. It replaces the fixed load-use detector and two-source forwarding unit. A per-register latency scoreboard stalls decode for producers of any fixed latency, or for variable-latency producers that signal their own completion. It also handles WAW ordering and cancellation of flushed producers, and it generates forwarding selects over NFWD pipeline sources.

## Interface
- NREG, 32, number of architectural registers; x0 is never tracked or forwarded
- AW, $clog2(NREG), register index width (derived, not overridden)
- NFWD, 2, number of forwarding sources; source 1 is youngest (EX/MEM), source NFWD is oldest
- LW, 3, latency counter width; value 2**LW-1 (LVAR) marks a variable-latency producer
- SW, $clog2(NFWD+1), forwarding select width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- hold  in  1  global halt; freezes scoreboard (completions still honoured)
- flush  in  1  branch/jump taken in EX; kills ID and EX instructions
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  AW  ID source registers
- id_rs1_used, id_rs2_used  in  1  source actually read by the ID instruction
- id_rd  in  AW  ID destination
- id_regwrite  in  1  ID instruction writes id_rd
- id_lat  in  LW  cycles of decode stall owed to dependents (0 = fully forwardable, 1 = load, LVAR = wait for completion)
- ex_sb_valid  in  1  EX instruction created a scoreboard entry
- ex_rd  in  AW  EX destination
- ex_rs1, ex_rs2  in  AW  EX operand registers
- fwd_rd  in  NFWD*AW  destination of each forwarding source; slice k-1 is source k
- fwd_we  in  NFWD  source k will write its rd
- cpl_valid  in  1  variable-latency unit completion
- cpl_rd  in  AW  register completed
- id_stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- fwd_a_sel, fwd_b_sel  out  SW  0 = register file, k = source k
- busy_vec  out  NREG  debug: bit r = (cnt[r] != 0)

## Operation
- State: cnt[r] is LW bits wide, for r = 1..NREG-1. cnt[0] is constant 0.
- busy[r] = (cnt[r] != 0).
- id_stall = id_valid & ((id_rs1_used & busy[id_rs1]) | (id_rs2_used & busy[id_rs2]) | (id_regwrite & id_rd != 0 & busy[id_rd])). The last term is the WAW stall, so each register has at most one live entry.
- id_stall is purely combinational and does not depend on flush. The datapath gives flush priority.
- id_fire = id_valid & ~id_stall & ~flush & ~hold.
- Per-register next-state priority, highest first:
  1. reset: cnt = 0.
  2. cpl_valid & cpl_rd == r: cnt = 0. Honoured even during hold.
  3. flush & ex_sb_valid & ex_rd == r (and ~hold): cnt = 0.
  4. hold: cnt unchanged.
  5. id_fire & id_regwrite & id_rd == r & id_lat != 0: cnt = id_lat.
  6. cnt != 0 & cnt != LVAR: cnt = cnt - 1.
  7. Otherwise: unchanged.
- An LVAR entry never decrements; only cpl_valid, flush-kill or reset clears it.
- cpl_valid to a non-busy register has no effect.
- Fire and cpl to the same register cannot coincide with a live entry, because of the WAW stall. If they do coincide on a free register, fire wins.
- Forwarding, per operand (shown for fwd_a_sel with ex_rs1):
  - The select is the smallest k such that fwd_we[k-1] & fwd_rd[k-1] == ex_rs1 & ex_rs1 != 0.
  - If no k matches, the select is 0. Youngest source wins.
- Forwarding is purely combinational and independent of the scoreboard.

## Timing
- Reset values: all cnt = 0, so busy_vec = 0 and id_stall = 0 from the cycle after reset is sampled. fwd_*_sel follow their inputs combinationally.
- Latency rule: a producer fires in cycle t with id_lat = L (0 < L < LVAR). A dependent sitting in ID stalls in cycles t+1 … t+L and proceeds in cycle t+L+1, assuming no hold.
- hold cycles extend the stall one-for-one.
- L = 1 reproduces the classic one-bubble load-use stall.
- LVAR producer: the dependent stalls through the cycle in which cpl_valid is sampled and proceeds in the next cycle.
- Kill: a flush in the cycle the producer occupies EX clears its entry at that edge. The ID instruction is not issued in that cycle.
- A reset asserted mid-stall clears everything at the next edge.

## Test plan
- Load-use: fire lw x5 with L=1, then add x6,x5,x1 in ID. Required: id_stall=1 for exactly 1 cycle, busy_vec[5] is 1 for 1 cycle, and x6 issues in cycle t+2.
- Multi-cycle, including hold: fire with rd=x7 and L=4, then a dependent on x7 in ID, with hold asserted 2 cycles mid-stall. Required: 6 stall cycles.
- Variable latency plus WAW: fire rd=x9 with L=LVAR, then an instruction writing x9 in ID. Required: id_stall stays 1 for 20 cycles. cpl_valid with cpl_rd=9 clears it, and the writer issues in the next cycle.
- Kill: an LVAR producer on x3 is in EX (ex_sb_valid=1) when flush=1. Required: busy_vec[3]=0 after the edge, with no cpl needed.
- Forward priority with NFWD=3: ex_rs1=x4, all three sources writing x4. Required: fwd_a_sel=1.
  - Drop fwd_we[0]: required fwd_a_sel=2.
  - ex_rs1=x0 with all sources writing x0: required fwd_a_sel=0.
- Reset mid-operation: busy on x2, x8 and x31, then reset for 1 cycle. Required: busy_vec=0 and id_stall=0 on the following cycle.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute hazard bus between the pipeline control and hazard_scoreboard.
// master drives pipeline state and reads stall/forwarding decisions; slave is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int NREG = 32,
    parameter int NFWD = 2,
    parameter int LW   = 3
);
    localparam int AW = $clog2(NREG);
    localparam int SW = $clog2(NFWD + 1);

    logic               hold;
    logic               flush;
    logic               id_valid;
    logic [AW-1:0]      id_rs1;
    logic [AW-1:0]      id_rs2;
    logic               id_rs1_used;
    logic               id_rs2_used;
    logic [AW-1:0]      id_rd;
    logic               id_regwrite;
    logic [LW-1:0]      id_lat;
    logic               ex_sb_valid;
    logic [AW-1:0]      ex_rd;
    logic [AW-1:0]      ex_rs1;
    logic [AW-1:0]      ex_rs2;
    logic [NFWD*AW-1:0] fwd_rd;
    logic [NFWD-1:0]    fwd_we;
    logic               cpl_valid;
    logic [AW-1:0]      cpl_rd;
    logic               id_stall;
    logic [SW-1:0]      fwd_a_sel;
    logic [SW-1:0]      fwd_b_sel;
    logic [NREG-1:0]    busy_vec;

    modport master (
        output hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_lat, ex_sb_valid, ex_rd, ex_rs1, ex_rs2,
               fwd_rd, fwd_we, cpl_valid, cpl_rd,
        input  id_stall, fwd_a_sel, fwd_b_sel, busy_vec
    );

    modport slave (
        input  hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_lat, ex_sb_valid, ex_rd, ex_rs1, ex_rs2,
               fwd_rd, fwd_we, cpl_valid, cpl_rd,
        output id_stall, fwd_a_sel, fwd_b_sel, busy_vec
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard producing decode stalls (RAW and WAW),
// plus youngest-first operand forwarding selects over NFWD pipeline sources.
module hazard_scoreboard #(
    parameter int NREG = 32,
    parameter int NFWD = 2,
    parameter int LW   = 3
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hs
);
    localparam int AW = $clog2(NREG);
    localparam int SW = $clog2(NFWD + 1);
    localparam logic [LW-1:0] LVAR = {LW{1'b1}};
    localparam logic [LW-1:0] ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] X0   = {AW{1'b0}};

    logic [LW-1:0]   cnt_r     [NREG];
    logic [LW-1:0]   cnt_nxt_s [NREG];
    logic [NREG-1:0] busy_s;
    logic            id_stall_s;
    logic            id_fire_s;
    logic [SW-1:0]   fwd_a_s;
    logic [SW-1:0]   fwd_b_s;

    // Occupancy view of the counters; x0 is never busy
    always_comb begin
        busy_s = {NREG{1'b0}};
        for (int r = 1; r < NREG; r++) begin
            busy_s[r] = (cnt_r[r] != ZERO);
        end
    end

    // RAW on either used source, or WAW on a live destination, holds decode
    always_comb begin
        id_stall_s = hs.id_valid &
                     ((hs.id_rs1_used & busy_s[hs.id_rs1]) |
                      (hs.id_rs2_used & busy_s[hs.id_rs2]) |
                      (hs.id_regwrite & (hs.id_rd != X0) & busy_s[hs.id_rd]));
        id_fire_s  = hs.id_valid & ~id_stall_s & ~hs.flush & ~hs.hold;
    end

    // Next counter value. A completion only matters on a busy register, which
    // lets a same-cycle fire to a free register take effect.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt_s[r] = cnt_r[r];
            if (r == 0) begin
                cnt_nxt_s[r] = ZERO;
            end else if (hs.cpl_valid && (hs.cpl_rd == AW'(r)) && busy_s[r]) begin
                cnt_nxt_s[r] = ZERO;
            end else if (hs.flush && !hs.hold && hs.ex_sb_valid && (hs.ex_rd == AW'(r))) begin
                cnt_nxt_s[r] = ZERO;
            end else if (hs.hold) begin
                cnt_nxt_s[r] = cnt_r[r];
            end else if (id_fire_s && hs.id_regwrite && (hs.id_rd == AW'(r)) && (hs.id_lat != ZERO)) begin
                cnt_nxt_s[r] = hs.id_lat;
            end else if ((cnt_r[r] != ZERO) && (cnt_r[r] != LVAR)) begin
                cnt_nxt_s[r] = cnt_r[r] - ONE;
            end else begin
                cnt_nxt_s[r] = cnt_r[r];
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (reset) begin
                cnt_r[r] <= ZERO;
            end else begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
        end
    end

    // Forwarding selects: scan oldest to youngest so the youngest match lands last
    always_comb begin
        fwd_a_s = {SW{1'b0}};
        fwd_b_s = {SW{1'b0}};
        for (int k = NFWD; k >= 1; k--) begin
            if (hs.fwd_we[k-1] && (hs.fwd_rd[(k-1)*AW +: AW] == hs.ex_rs1) && (hs.ex_rs1 != X0)) begin
                fwd_a_s = SW'(k);
            end else begin
                fwd_a_s = fwd_a_s;
            end
            if (hs.fwd_we[k-1] && (hs.fwd_rd[(k-1)*AW +: AW] == hs.ex_rs2) && (hs.ex_rs2 != X0)) begin
                fwd_b_s = SW'(k);
            end else begin
                fwd_b_s = fwd_b_s;
            end
        end
    end

    assign hs.id_stall  = id_stall_s;
    assign hs.fwd_a_sel = fwd_a_s;
    assign hs.fwd_b_sel = fwd_b_s;
    assign hs.busy_vec  = busy_s;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic checked against
// a timestamp-based model (per register: cycle at which it frees, or pending variable).
module tb_hazard_scoreboard;
    localparam int NREG = 32;
    localparam int NFWD = 3;
    localparam int LW   = 3;
    localparam int AW   = 5;
    localparam int LVAR = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(NREG), .NFWD(NFWD), .LW(LW)) bus ();
    hazard_scoreboard #(.NREG(NREG), .NFWD(NFWD), .LW(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .hs    (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int ready_at [NREG];
    bit var_p    [NREG];
    int cyc = 0;

    function automatic bit m_busy(int r);
        return (r != 0) && (var_p[r] || (ready_at[r] > cyc));
    endfunction

    function automatic logic [NREG-1:0] m_busy_vec();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = m_busy(r);
        return v;
    endfunction

    function automatic bit m_stall();
        return bus.id_valid && ((bus.id_rs1_used && m_busy(int'(bus.id_rs1))) ||
                                (bus.id_rs2_used && m_busy(int'(bus.id_rs2))) ||
                                (bus.id_regwrite && m_busy(int'(bus.id_rd))));
    endfunction

    function automatic int m_fwd(logic [AW-1:0] rs);
        for (int k = 1; k <= NFWD; k++) begin
            if (rs != 5'd0 && bus.fwd_we[k-1] && bus.fwd_rd[(k-1)*AW +: AW] == rs) return k;
        end
        return 0;
    endfunction

    task automatic idle_inputs();
        bus.hold = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
        bus.id_rd = 5'd0; bus.id_regwrite = 1'b0; bus.id_lat = 3'd0;
        bus.ex_sb_valid = 1'b0; bus.ex_rd = 5'd0; bus.ex_rs1 = 5'd0; bus.ex_rs2 = 5'd0;
        bus.fwd_rd = 15'd0; bus.fwd_we = 3'd0; bus.cpl_valid = 1'b0; bus.cpl_rd = 5'd0;
    endtask

    // Advance one clock and apply the same edge to the model
    task automatic tick();
        bit busy_now [NREG];
        bit fire;
        bit rst_c;
        for (int r = 0; r < NREG; r++) busy_now[r] = m_busy(r);
        fire  = bus.id_valid && !m_stall() && !bus.flush && !bus.hold;
        rst_c = reset;
        @(posedge clk);
        for (int r = 1; r < NREG; r++) begin
            if (rst_c) begin
                ready_at[r] = 0; var_p[r] = 1'b0;
            end else if (bus.cpl_valid && int'(bus.cpl_rd) == r && busy_now[r]) begin
                ready_at[r] = 0; var_p[r] = 1'b0;
            end else if (bus.flush && !bus.hold && bus.ex_sb_valid && int'(bus.ex_rd) == r) begin
                ready_at[r] = 0; var_p[r] = 1'b0;
            end else if (bus.hold) begin
                if (busy_now[r] && !var_p[r]) ready_at[r] = ready_at[r] + 1;
            end else if (fire && bus.id_regwrite && int'(bus.id_rd) == r && bus.id_lat != 3'd0) begin
                if (int'(bus.id_lat) == LVAR) var_p[r] = 1'b1;
                else ready_at[r] = cyc + 1 + int'(bus.id_lat);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic fire_producer(int rd, int lat);
        bus.id_valid = 1'b1; bus.id_regwrite = 1'b1;
        bus.id_rd = AW'(rd); bus.id_lat = 3'(lat);
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        apply_reset();
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
        bus.id_rd = 5'd5; bus.id_regwrite = 1'b1;
        #1;
        vectors++;
        if (bus.busy_vec !== 32'd0) begin
            miscompares++; $display("FAIL reset_busy: got %h expected 0", bus.busy_vec);
        end
        vectors++;
        if (bus.id_stall !== 1'b0) begin
            miscompares++; $display("FAIL reset_stall: got %b expected 0", bus.id_stall);
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        int n = 0;
        int nb = 0;
        apply_reset();
        fire_producer(5, 1);
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd1;
        bus.id_rs1_used = 1'b1; bus.id_rs2_used = 1'b1; bus.id_rd = 5'd6; bus.id_regwrite = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.busy_vec[5]) nb++;
            if (!bus.id_stall) break;
            n++;
            tick();
        end
        vectors++;
        if (n !== 1) begin
            miscompares++; $display("FAIL load_use_stalls: got %0d expected 1", n);
        end
        vectors++;
        if (nb !== 1) begin
            miscompares++; $display("FAIL load_use_busy5: got %0d cycles expected 1", nb);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (bus.busy_vec[6] !== 1'b0) begin
            miscompares++; $display("FAIL load_use_x6_entry: got %b expected 0", bus.busy_vec[6]);
        end
    endtask

    task automatic test_multicycle_hold();
        int n = 0;
        apply_reset();
        fire_producer(7, 4);
        bus.id_valid = 1'b1; bus.id_rs2 = 5'd7; bus.id_rs2_used = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.hold = (n == 1 || n == 2);
            #1;
            if (!bus.id_stall) break;
            n++;
            tick();
        end
        vectors++;
        if (n !== 6) begin
            miscompares++; $display("FAIL multicycle_hold_stalls: got %0d expected 6", n);
        end
        bus.hold = 1'b0;
        tick();
        idle_inputs();
    endtask

    task automatic test_lvar_waw();
        int bad = 0;
        apply_reset();
        fire_producer(9, LVAR);
        bus.id_valid = 1'b1; bus.id_rd = 5'd9; bus.id_regwrite = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.id_stall !== 1'b1) bad++;
            tick();
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++; $display("FAIL lvar_waw_hold: got %0d non-stall cycles expected 0", bad);
        end
        bus.cpl_valid = 1'b1; bus.cpl_rd = 5'd9;
        #1;
        vectors++;
        if (bus.id_stall !== 1'b1) begin
            miscompares++; $display("FAIL lvar_cpl_cycle_stall: got %b expected 1", bus.id_stall);
        end
        tick();
        bus.cpl_valid = 1'b0;
        #1;
        vectors++;
        if (bus.id_stall !== 1'b0 || bus.busy_vec[9] !== 1'b0) begin
            miscompares++;
            $display("FAIL lvar_release: got stall=%b busy9=%b expected 0/0", bus.id_stall, bus.busy_vec[9]);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_kill();
        apply_reset();
        fire_producer(3, LVAR);
        bus.ex_sb_valid = 1'b1; bus.ex_rd = 5'd3; bus.flush = 1'b1;
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd3; bus.id_rs1_used = 1'b1;
        #1;
        vectors++;
        if (bus.busy_vec[3] !== 1'b1) begin
            miscompares++; $display("FAIL kill_before: got %b expected 1", bus.busy_vec[3]);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (bus.busy_vec !== 32'd0) begin
            miscompares++; $display("FAIL kill_after: got %h expected 0", bus.busy_vec);
        end
    endtask

    task automatic test_forward();
        idle_inputs();
        bus.ex_rs1 = 5'd4; bus.fwd_rd = {5'd4, 5'd4, 5'd4}; bus.fwd_we = 3'b111;
        #1;
        vectors++;
        if (bus.fwd_a_sel !== 2'd1) begin
            miscompares++; $display("FAIL fwd_youngest: got %0d expected 1", bus.fwd_a_sel);
        end
        bus.fwd_we = 3'b110;
        #1;
        vectors++;
        if (bus.fwd_a_sel !== 2'd2) begin
            miscompares++; $display("FAIL fwd_second: got %0d expected 2", bus.fwd_a_sel);
        end
        bus.ex_rs2 = 5'd4; bus.fwd_we = 3'b100;
        #1;
        vectors++;
        if (bus.fwd_b_sel !== 2'd3) begin
            miscompares++; $display("FAIL fwd_b_oldest: got %0d expected 3", bus.fwd_b_sel);
        end
        bus.ex_rs1 = 5'd0; bus.fwd_rd = 15'd0; bus.fwd_we = 3'b111;
        #1;
        vectors++;
        if (bus.fwd_a_sel !== 2'd0) begin
            miscompares++; $display("FAIL fwd_x0: got %0d expected 0", bus.fwd_a_sel);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        fire_producer(2, LVAR);
        fire_producer(8, 5);
        fire_producer(31, 6);
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd31; bus.id_rs1_used = 1'b1;
        #1;
        vectors++;
        if (bus.busy_vec !== 32'h8000_0104 || bus.id_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_before: got busy=%h stall=%b expected 80000104/1", bus.busy_vec, bus.id_stall);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.busy_vec !== 32'd0 || bus.id_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_after: got busy=%h stall=%b expected 0/0", bus.busy_vec, bus.id_stall);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [NREG-1:0] exp_busy;
        bit exp_stall;
        int exp_a;
        int exp_b;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 299) == 0);
            bus.hold        = ($urandom_range(0, 7) == 0);
            bus.flush       = ($urandom_range(0, 7) == 0);
            bus.id_valid    = ($urandom_range(0, 3) != 0);
            bus.id_rs1      = 5'($urandom_range(0, 7));
            bus.id_rs2      = 5'($urandom_range(0, 7));
            bus.id_rs1_used = 1'($urandom_range(0, 1));
            bus.id_rs2_used = 1'($urandom_range(0, 1));
            bus.id_rd       = 5'($urandom_range(0, 7));
            bus.id_regwrite = ($urandom_range(0, 3) != 0);
            bus.id_lat      = 3'($urandom_range(0, 7));
            bus.ex_sb_valid = 1'($urandom_range(0, 1));
            bus.ex_rd       = 5'($urandom_range(0, 7));
            bus.ex_rs1      = 5'($urandom_range(0, 7));
            bus.ex_rs2      = 5'($urandom_range(0, 7));
            bus.fwd_rd      = 15'($urandom_range(0, 32767)) & 15'b00111_00111_00111;
            bus.fwd_we      = 3'($urandom_range(0, 7));
            bus.cpl_valid   = ($urandom_range(0, 2) == 0);
            bus.cpl_rd      = 5'($urandom_range(0, 7));
            #1;
            exp_busy  = m_busy_vec();
            exp_stall = m_stall();
            exp_a     = m_fwd(bus.ex_rs1);
            exp_b     = m_fwd(bus.ex_rs2);
            vectors++;
            if (bus.busy_vec !== exp_busy) begin
                miscompares++; $display("FAIL rnd_busy cyc %0d: got %h expected %h", cyc, bus.busy_vec, exp_busy);
            end
            vectors++;
            if (bus.id_stall !== exp_stall) begin
                miscompares++; $display("FAIL rnd_stall cyc %0d: got %b expected %b", cyc, bus.id_stall, exp_stall);
            end
            vectors++;
            if (int'(bus.fwd_a_sel) !== exp_a || int'(bus.fwd_b_sel) !== exp_b) begin
                miscompares++;
                $display("FAIL rnd_fwd cyc %0d: got a=%0d b=%0d expected a=%0d b=%0d",
                         cyc, bus.fwd_a_sel, bus.fwd_b_sel, exp_a, exp_b);
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            ready_at[r] = 0;
            var_p[r] = 1'b0;
        end
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        tick();
        test_reset();
        test_load_use();
        test_multicycle_hold();
        test_lvar_waw();
        test_kill();
        test_forward();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
